// File: rtl/mcyc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM state codes, opcodes,
// ALU operation classes and ALU control words.
package mcyc_pkg;

  localparam logic [4:0] S_FETCH   = 5'd0;
  localparam logic [4:0] S_DECODE  = 5'd1;
  localparam logic [4:0] S_MEMADR  = 5'd2;
  localparam logic [4:0] S_MEMRD   = 5'd3;
  localparam logic [4:0] S_MEMWB   = 5'd4;
  localparam logic [4:0] S_MEMWR   = 5'd5;
  localparam logic [4:0] S_RTYPEEX = 5'd6;
  localparam logic [4:0] S_RTYPEWB = 5'd7;
  localparam logic [4:0] S_BEQEX   = 5'd8;
  localparam logic [4:0] S_BNEEX   = 5'd9;
  localparam logic [4:0] S_ADDIEX  = 5'd10;
  localparam logic [4:0] S_IMMEX   = 5'd11;
  localparam logic [4:0] S_IMMWB   = 5'd12;
  localparam logic [4:0] S_JEX     = 5'd13;
  localparam logic [4:0] S_JALEX   = 5'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_SLT, ALUOP_FUNCT
  } aluop_e;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Extended opcodes decode only when the build enables them.
  function automatic logic op_legal(input logic [5:0] opc, input logic ext);
    case (opc)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_BNE, OP_SLTI, OP_ANDI, OP_ORI, OP_JAL:      op_legal = ext;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcyc_aludec.sv
// ALU decoder: maps an operation class (or the R-type funct field) to the
// ALU control word, zero-extended to ALUC_W bits.
module mcyc_aludec
  import mcyc_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic [2:0]        aluop,
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] alucontrol
);

  logic [2:0] aluc3;

  always_comb begin
    aluc3 = ALUC_ADD;
    case (aluop)
      ALUOP_ADD: aluc3 = ALUC_ADD;
      ALUOP_SUB: aluc3 = ALUC_SUB;
      ALUOP_AND: aluc3 = ALUC_AND;
      ALUOP_OR:  aluc3 = ALUC_OR;
      ALUOP_SLT: aluc3 = ALUC_SLT;
      ALUOP_FUNCT: begin
        // Unknown funct codes fall back to add.
        case (funct)
          6'h20:   aluc3 = ALUC_ADD;
          6'h22:   aluc3 = ALUC_SUB;
          6'h24:   aluc3 = ALUC_AND;
          6'h25:   aluc3 = ALUC_OR;
          6'h2A:   aluc3 = ALUC_SLT;
          default: aluc3 = ALUC_ADD;
        endcase
      end
      default: aluc3 = ALUC_ADD;
    endcase
    alucontrol      = '0;
    alucontrol[2:0] = aluc3;
  end

endmodule

// File: rtl/mcyc_ctrl.sv
// Multi-cycle MIPS-style controller: FSM sequencing fetch/decode/execute with
// a stallable memory handshake, plus datapath select and strobe decode.
module mcyc_ctrl
  import mcyc_pkg::*;
#(
  parameter int WAIT_EN = 1,
  parameter int EXT_OPS = 1,
  parameter int ALUC_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pcen,
  output logic              memreq,
  output logic              memwrite,
  output logic              irwrite,
  output logic              regwrite,
  output logic              alusrca,
  output logic              iord,
  output logic              immzx,
  output logic [1:0]        memtoreg,
  output logic [1:0]        regdst,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              illegal_op,
  output logic [4:0]        state_o
);

  localparam logic EXT_OK = (EXT_OPS != 0);

  // Memory handshake: memreq is held high for the whole access and the access
  // completes in the cycle mem_ready=1; the FSM only advances in that cycle.
  logic mem_ok;
  assign mem_ok = (WAIT_EN != 0) ? mem_ready : 1'b1;

  logic [4:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       pcwrite, beq_branch, bne_branch;
  logic       memreq_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;
  aluop_e     aluop;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pcwrite    = 1'b0;
    beq_branch = 1'b0;
    bne_branch = 1'b0;
    memreq_c   = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    immzx      = 1'b0;
    memtoreg   = 2'd0;
    regdst     = 2'd0;
    alusrcb    = 2'd0;
    pcsrc      = 2'd0;
    aluop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        memreq_c = 1'b1;
        if (mem_ok) begin
          irwrite_c = 1'b1;
          pcwrite   = 1'b1;
          alusrcb   = 2'd1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = op;
        alusrcb = 2'd3;
        case (op)
          OP_LW, OP_SW:                state_d = S_MEMADR;
          OP_RTYPE:                    state_d = S_RTYPEEX;
          OP_BEQ:                      state_d = S_BEQEX;
          OP_BNE:                      state_d = S_BNEEX;
          OP_ADDI:                     state_d = S_ADDIEX;
          OP_SLTI, OP_ANDI, OP_ORI:    state_d = S_IMMEX;
          OP_J:                        state_d = S_JEX;
          OP_JAL:                      state_d = S_JALEX;
          default:                     state_d = S_FETCH;
        endcase
        illegal_c = !op_legal(op, EXT_OK);
        if (illegal_c) state_d = S_FETCH;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memreq_c = 1'b1;
        iord     = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 2'd1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memreq_c   = 1'b1;
        memwrite_c = 1'b1;
        iord       = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst     = 2'd1;
        aluop      = ALUOP_FUNCT;
        state_d    = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'd1;
        beq_branch = (state_q == S_BEQEX);
        bne_branch = (state_q == S_BNEEX);
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        state_d = S_IMMWB;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        case (op_q)
          OP_ANDI: begin aluop = ALUOP_AND; immzx = 1'b1; end
          OP_ORI:  begin aluop = ALUOP_OR;  immzx = 1'b1; end
          default: aluop = ALUOP_SLT;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'd2;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_JALEX: begin
        pcsrc      = 2'd2;
        pcwrite    = 1'b1;
        regwrite_c = 1'b1;
        regdst     = 2'd2;
        memtoreg   = 2'd2;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Reset gates every strobe so an in-flight access is dropped immediately.
  assign pcen       = ~reset & (pcwrite | (beq_branch & zero) | (bne_branch & ~zero));
  assign memreq     = ~reset & memreq_c;
  assign memwrite   = ~reset & memwrite_c;
  assign irwrite    = ~reset & irwrite_c;
  assign regwrite   = ~reset & regwrite_c;
  assign illegal_op = ~reset & illegal_c;
  assign state_o    = state_q;

  mcyc_aludec #(.ALUC_W(ALUC_W)) u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Directed bench for mcyc_ctrl: a cycle-by-cycle vector table plus
// hand-written sequences for reset-in-stall and the EXT_OPS=0 build.
module tb_mcyc_ctrl;
  import mcyc_pkg::*;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, funct;

  logic pcen, memreq, memwrite, irwrite, regwrite, alusrca, iord, immzx, illegal_op;
  logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [4:0] state_o;

  logic d2_pcen, d2_memreq, d2_memwrite, d2_irwrite, d2_regwrite;
  logic d2_alusrca, d2_iord, d2_immzx, d2_illegal_op;
  logic [1:0] d2_memtoreg, d2_regdst, d2_alusrcb, d2_pcsrc;
  logic [3:0] d2_alucontrol;
  logic [4:0] d2_state_o;

  always #5 clk = ~clk;

  mcyc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memreq(memreq), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .immzx(immzx), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  mcyc_ctrl #(.EXT_OPS(0), .ALUC_W(4)) dut_base (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(d2_pcen), .memreq(d2_memreq), .memwrite(d2_memwrite), .irwrite(d2_irwrite),
    .regwrite(d2_regwrite), .alusrca(d2_alusrca), .iord(d2_iord), .immzx(d2_immzx),
    .memtoreg(d2_memtoreg), .regdst(d2_regdst), .alusrcb(d2_alusrcb), .pcsrc(d2_pcsrc),
    .alucontrol(d2_alucontrol), .illegal_op(d2_illegal_op), .state_o(d2_state_o)
  );

  logic [5:0]  strb;
  logic [10:0] sel;
  assign strb = {pcen, memreq, memwrite, irwrite, regwrite, illegal_op};
  assign sel  = {alusrca, iord, immzx, memtoreg, regdst, alusrcb, pcsrc};

  localparam logic [10:0] MA = 11'h400, MI = 11'h200, MZ = 11'h100, MM = 11'h0C0;
  localparam logic [10:0] MR = 11'h030, MB = 11'h00C, MP = 11'h003;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mrdy;
    logic [4:0]  st;
    logic [5:0]  strb;
    logic        achk;
    logic [2:0]  aluc;
    logic [10:0] sel;
    logic [10:0] mask;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0, n_cmp = 0, n_miss = 0;

  function automatic logic [10:0] sl(input logic a, input logic io, input logic zx,
                                     input logic [1:0] mtr, input logic [1:0] rd,
                                     input logic [1:0] sb, input logic [1:0] ps);
    return {a, io, zx, mtr, rd, sb, ps};
  endfunction

  task automatic v(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic z,
                   input logic r, input logic [4:0] st, input logic [5:0] sb, input logic ac,
                   input logic [2:0] al, input logic [10:0] s, input logic [10:0] m);
    vec_t e;
    e.rst = rst; e.op = o; e.funct = f; e.zero = z; e.mrdy = r; e.st = st;
    e.strb = sb; e.achk = ac; e.aluc = al; e.sel = s; e.mask = m;
    vecs.push_back(e);
  endtask

  // One instruction fetch (memory ready) followed by its decode cycle.
  task automatic fd(input logic [5:0] o, input logic [5:0] f);
    v(0, o, f, 0, 1, S_FETCH,  6'b110100, 1, 3'b010, sl(0,0,0,0,0,1,0), MA|MI|MB|MP);
    v(0, o, f, 0, 1, S_DECODE, 6'b000000, 1, 3'b010, sl(0,0,0,0,0,3,0), MA|MB);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic m);
    reset = r; op = o; funct = f; zero = z; mem_ready = m;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then lw with 3 FETCH stall cycles and 2 MEMRD stall cycles.
    v(1, 6'h23, 6'h00, 0, 1, S_FETCH, 6'b000000, 0, 3'b000, 11'h0, 11'h0);
    for (int k = 0; k < 3; k++)
      v(0, 6'h23, 6'h00, 0, 0, S_FETCH, 6'b010000, 0, 3'b000, sl(0,0,0,0,0,0,0), MI|MB);
    fd(6'h23, 6'h00);
    v(0, 6'h23, 6'h00, 0, 1, S_MEMADR, 6'b000000, 1, 3'b010, sl(1,0,0,0,0,2,0), MA|MB);
    for (int k = 0; k < 2; k++)
      v(0, 6'h23, 6'h00, 0, 0, S_MEMRD, 6'b010000, 0, 3'b000, sl(0,1,0,0,0,0,0), MI);
    v(0, 6'h23, 6'h00, 0, 1, S_MEMRD, 6'b010000, 0, 3'b000, sl(0,1,0,0,0,0,0), MI);
    v(0, 6'h23, 6'h00, 0, 1, S_MEMWB, 6'b000010, 0, 3'b000, sl(0,0,0,1,0,0,0), MM|MR);
    // sw without stall
    fd(6'h2B, 6'h00);
    v(0, 6'h2B, 6'h00, 0, 1, S_MEMADR, 6'b000000, 1, 3'b010, sl(1,0,0,0,0,2,0), MA|MB);
    v(0, 6'h2B, 6'h00, 0, 1, S_MEMWR,  6'b011000, 0, 3'b000, sl(0,1,0,0,0,0,0), MI);
    // bne taken, then not taken
    fd(6'h05, 6'h00);
    v(0, 6'h05, 6'h00, 0, 1, S_BNEEX, 6'b100000, 1, 3'b110, sl(1,0,0,0,0,0,1), MA|MB|MP);
    fd(6'h05, 6'h00);
    v(0, 6'h05, 6'h00, 1, 1, S_BNEEX, 6'b000000, 1, 3'b110, sl(1,0,0,0,0,0,1), MA|MB|MP);
    // jal
    fd(6'h03, 6'h00);
    v(0, 6'h03, 6'h00, 0, 1, S_JALEX, 6'b100010, 0, 3'b000, sl(0,0,0,2,2,0,2), MM|MR|MP);
    // ori; op input changes after decode, latched opcode must still rule
    fd(6'h0D, 6'h00);
    v(0, 6'h0A, 6'h00, 0, 1, S_IMMEX, 6'b000000, 1, 3'b001, sl(1,0,1,0,0,2,0), MA|MZ|MB);
    v(0, 6'h00, 6'h00, 0, 1, S_IMMWB, 6'b000010, 0, 3'b000, sl(0,0,0,0,0,0,0), MM|MR);
    // R-type slt, then unknown funct
    fd(6'h00, 6'h2A);
    v(0, 6'h00, 6'h2A, 0, 1, S_RTYPEEX, 6'b000000, 1, 3'b111, sl(1,0,0,0,0,0,0), MA|MB);
    v(0, 6'h00, 6'h2A, 0, 1, S_RTYPEWB, 6'b000010, 0, 3'b000, sl(0,0,0,0,1,0,0), MM|MR);
    fd(6'h00, 6'h3F);
    v(0, 6'h00, 6'h3F, 0, 1, S_RTYPEEX, 6'b000000, 1, 3'b010, sl(1,0,0,0,0,0,0), MA|MB);
    v(0, 6'h00, 6'h3F, 0, 1, S_RTYPEWB, 6'b000010, 0, 3'b000, sl(0,0,0,0,1,0,0), MM|MR);
    // illegal opcode pulses once and returns to FETCH
    v(0, 6'h3F, 6'h00, 0, 1, S_FETCH,  6'b110100, 0, 3'b000, 11'h0, 11'h0);
    v(0, 6'h3F, 6'h00, 0, 1, S_DECODE, 6'b000001, 0, 3'b000, 11'h0, 11'h0);
    v(0, 6'h3F, 6'h00, 0, 0, S_FETCH,  6'b010000, 0, 3'b000, 11'h0, 11'h0);
    // beq taken, slti, j, addi, andi
    fd(6'h04, 6'h00);
    v(0, 6'h04, 6'h00, 1, 1, S_BEQEX, 6'b100000, 1, 3'b110, sl(1,0,0,0,0,0,1), MA|MB|MP);
    fd(6'h0A, 6'h00);
    v(0, 6'h0A, 6'h00, 0, 1, S_IMMEX, 6'b000000, 1, 3'b111, sl(1,0,0,0,0,2,0), MA|MZ|MB);
    v(0, 6'h0A, 6'h00, 0, 1, S_IMMWB, 6'b000010, 0, 3'b000, sl(0,0,0,0,0,0,0), MM|MR);
    fd(6'h02, 6'h00);
    v(0, 6'h02, 6'h00, 0, 1, S_JEX, 6'b100000, 0, 3'b000, sl(0,0,0,0,0,0,2), MP);
    fd(6'h08, 6'h00);
    v(0, 6'h08, 6'h00, 0, 1, S_ADDIEX, 6'b000000, 1, 3'b010, sl(1,0,0,0,0,2,0), MA|MB);
    v(0, 6'h08, 6'h00, 0, 1, S_IMMWB,  6'b000010, 0, 3'b000, sl(0,0,0,0,0,0,0), MM|MR);
    fd(6'h0C, 6'h00);
    v(0, 6'h0C, 6'h00, 0, 1, S_IMMEX, 6'b000000, 1, 3'b000, sl(1,0,1,0,0,2,0), MA|MZ|MB);
    v(0, 6'h0C, 6'h00, 0, 1, S_IMMWB, 6'b000010, 0, 3'b000, sl(0,0,0,0,0,0,0), MM|MR);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mrdy);
      @(negedge clk);
      n_vec++;
      chk("state", i, 32'(state_o), 32'(vecs[i].st));
      chk("strobes", i, 32'(strb), 32'(vecs[i].strb));
      if (vecs[i].achk) chk("alucontrol", i, 32'(alucontrol), 32'(vecs[i].aluc));
      if (vecs[i].mask != 11'h0) chk("selects", i, 32'(sel & vecs[i].mask), 32'(vecs[i].sel & vecs[i].mask));
      next_cycle();
    end

    // sw stalled in MEMWR, reset asserted mid-stall.
    drive(1, 6'h2B, 6'h00, 0, 1);
    next_cycle();
    drive(0, 6'h2B, 6'h00, 0, 1);
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    chk("sw_stall_state", 0, 32'(state_o), 32'(S_MEMWR));
    chk("sw_stall_memwrite", 0, 32'(memwrite), 32'd1);
    next_cycle();
    n_vec++;
    chk("sw_stall2_memwrite", 1, 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    n_vec++;
    chk("rst_memwrite", 2, 32'(memwrite), 32'd0);
    chk("rst_memreq", 2, 32'(memreq), 32'd0);
    chk("rst_state", 2, 32'(state_o), 32'(S_FETCH));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    chk("first_memreq", 3, 32'(memreq), 32'd1);
    chk("first_state", 3, 32'(state_o), 32'(S_FETCH));

    // ori on the EXT_OPS=0 build: illegal pulse, never a register write.
    next_cycle();
    drive(0, 6'h0D, 6'h00, 0, 1);
    next_cycle();
    @(negedge clk);
    n_vec++;
    chk("base_illegal", 4, 32'(d2_illegal_op), 32'd1);
    chk("base_decode_aluc", 4, 32'(d2_alucontrol), 32'h2);
    chk("base_regwrite_dec", 4, 32'(d2_regwrite), 32'd0);
    chk("ext_illegal", 4, 32'(illegal_op), 32'd0);
    next_cycle();
    @(negedge clk);
    n_vec++;
    chk("base_state", 5, 32'(d2_state_o), 32'(S_FETCH));
    chk("base_illegal_pulse", 5, 32'(d2_illegal_op), 32'd0);
    chk("base_regwrite", 5, 32'(d2_regwrite), 32'd0);
    chk("ext_state", 5, 32'(state_o), 32'(S_IMMEX));
    chk("ext_immzx", 5, 32'(immzx), 32'd1);
    next_cycle();
    @(negedge clk);
    n_vec++;
    chk("ext_immwb_regwrite", 6, 32'(regwrite), 32'd1);
    chk("base_regwrite2", 6, 32'(d2_regwrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
